// File: rtl/coletor_digitos.sv
// ----------------------------------------------------------------------------
// coletor_digitos
//
// Keypad-side producer of the senhaPac_t digit packet. Decoded key presses are
// collected into a MAX_DIGITS-deep BCD buffer that is shown live on
// digitos_value. '#' commits the buffer, '*' clears it (or, when already
// empty, emits the all-B exit packet), and an idle non-empty buffer times out
// into the all-E packet. A commit is signalled by a one-cycle digitos_valid
// pulse during which digitos_value holds the packet.
//
// Ports
//   clk           in   system clock
//   rst           in   synchronous, active-high reset
//   enable        in   collection enable; low clears the buffer, no pulses
//   key_valid     in   one-cycle strobe, key_code carries a decoded key
//   key_code      in   0-9 digit, A '*', B '#', C-F ignored
//   digitos_value out  live buffer / committed packet, digits[0] = newest,
//                      unused digits read 0xF
//   digitos_valid out  one-cycle commit pulse
//   digit_count   out  digits currently buffered, 0..MAX_DIGITS
// ----------------------------------------------------------------------------
module coletor_digitos #(
  parameter int unsigned MAX_DIGITS     = 20,
  parameter int unsigned TIMEOUT_CYCLES = 5000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic                      key_valid,
  input  logic [3:0]                key_code,
  output logic [MAX_DIGITS*4-1:0]   digitos_value,
  output logic                      digitos_valid,
  output logic [4:0]                digit_count
);

  localparam int unsigned PW = MAX_DIGITS * 4;
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  // Reserved packets: empty buffer / skip, exit-save, timeout.
  localparam logic [PW-1:0] PKT_EMPTY   = {MAX_DIGITS{4'hF}};
  localparam logic [PW-1:0] PKT_EXIT    = {MAX_DIGITS{4'hB}};
  localparam logic [PW-1:0] PKT_TIMEOUT = {MAX_DIGITS{4'hE}};

  localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [4:0]    CNT_MAX  = 5'(MAX_DIGITS);

  localparam logic [3:0] KEY_STAR = 4'hA;
  localparam logic [3:0] KEY_HASH = 4'hB;

  typedef enum logic [0:0] {
    StCollect,
    StEmit
  } state_e;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  // r_value doubles as the digit buffer while collecting and as the packet
  // register during the emit cycle; the buffer is empty whenever we are in
  // StEmit, so no separate storage is needed.
  state_e          r_state;
  logic [PW-1:0]   r_value;
  logic [4:0]      r_count;
  logic [TW-1:0]   r_tmr;
  logic            r_valid;

  state_e          w_state_nxt;
  logic [PW-1:0]   w_value_nxt;
  logic [4:0]      w_count_nxt;
  logic [TW-1:0]   w_tmr_nxt;
  logic            w_valid_nxt;

  // --------------------------------------------------------------------------
  // Key decode
  // --------------------------------------------------------------------------
  logic w_is_digit;
  logic w_is_star;
  logic w_is_hash;
  logic w_buf_empty;
  logic w_tmr_expired;

  assign w_is_digit    = key_valid && (key_code <= 4'h9);
  assign w_is_star     = key_valid && (key_code == KEY_STAR);
  assign w_is_hash     = key_valid && (key_code == KEY_HASH);
  assign w_buf_empty   = (r_count == 5'd0);
  assign w_tmr_expired = !w_buf_empty && (r_tmr == TMR_LAST);

  // --------------------------------------------------------------------------
  // Next-state / output logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_value_nxt = r_value;
    w_count_nxt = r_count;
    w_tmr_nxt   = r_tmr;
    w_valid_nxt = 1'b0;

    if (!enable) begin
      w_state_nxt = StCollect;
      w_value_nxt = PKT_EMPTY;
      w_count_nxt = 5'd0;
      w_tmr_nxt   = '0;
    end else begin
      unique case (r_state)
        StEmit: begin
          // Keys arriving during the pulse are dropped.
          w_state_nxt = StCollect;
          w_value_nxt = PKT_EMPTY;
          w_count_nxt = 5'd0;
          w_tmr_nxt   = '0;
        end

        StCollect: begin
          if (w_is_digit) begin
            // Shift up; the oldest digit falls off the top when full.
            w_value_nxt = {r_value[PW-5:0], key_code};
            w_count_nxt = (r_count < CNT_MAX) ? r_count + 5'd1 : CNT_MAX;
            w_tmr_nxt   = '0;
          end else if (w_is_hash) begin
            // Packet is the current buffer (all-F when empty).
            w_state_nxt = StEmit;
            w_value_nxt = r_value;
            w_count_nxt = 5'd0;
            w_tmr_nxt   = '0;
            w_valid_nxt = 1'b1;
          end else if (w_is_star) begin
            w_count_nxt = 5'd0;
            w_tmr_nxt   = '0;
            if (w_buf_empty) begin
              w_state_nxt = StEmit;
              w_value_nxt = PKT_EXIT;
              w_valid_nxt = 1'b1;
            end else begin
              w_value_nxt = PKT_EMPTY;
            end
          end else if (w_tmr_expired) begin
            // Only reached when no accepted key is present: a key wins.
            w_state_nxt = StEmit;
            w_value_nxt = PKT_TIMEOUT;
            w_count_nxt = 5'd0;
            w_tmr_nxt   = '0;
            w_valid_nxt = 1'b1;
          end else if (!w_buf_empty) begin
            // Codes C-F land here too and do not restart the timer.
            w_tmr_nxt = r_tmr + TW'(1);
          end else begin
            w_tmr_nxt = '0;
          end
        end

        default: begin
          w_state_nxt = StCollect;
          w_value_nxt = PKT_EMPTY;
          w_count_nxt = 5'd0;
          w_tmr_nxt   = '0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StCollect;
      r_value <= PKT_EMPTY;
      r_count <= 5'd0;
      r_tmr   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_value <= w_value_nxt;
      r_count <= w_count_nxt;
      r_tmr   <= w_tmr_nxt;
      r_valid <= w_valid_nxt;
    end
  end

  assign digitos_value = r_value;
  assign digitos_valid = r_valid;
  assign digit_count   = r_count;

endmodule

// File: tb/tb_coletor_digitos.sv
// ----------------------------------------------------------------------------
// Testbench for coletor_digitos. A queue-based reference model predicts every
// committed packet into a scoreboard; a monitor checks the DUT outputs each
// cycle and pops the scoreboard on every digitos_valid pulse.
// ----------------------------------------------------------------------------
module tb_coletor_digitos;

  localparam int unsigned ND = 20;
  localparam int unsigned TO = 8;
  localparam int unsigned PW = ND * 4;

  logic           clk       = 1'b0;
  logic           rst       = 1'b1;
  logic           enable    = 1'b1;
  logic           key_valid = 1'b0;
  logic [3:0]     key_code  = 4'h0;
  logic [PW-1:0]  digitos_value;
  logic           digitos_valid;
  logic [4:0]     digit_count;

  always #5 clk = ~clk;

  coletor_digitos #(
    .MAX_DIGITS     (ND),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .key_valid     (key_valid),
    .key_code      (key_code),
    .digitos_value (digitos_value),
    .digitos_valid (digitos_valid),
    .digit_count   (digit_count)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: digits kept as a list, newest first.
  // --------------------------------------------------------------------------
  int            m_dig[$];
  int            m_idle = 0;
  bit            m_emit = 1'b0;
  logic [PW-1:0] m_pkt  = '1;
  logic [PW-1:0] sb[$];

  function automatic logic [PW-1:0] pack_digits();
    logic [PW-1:0] v;
    v = '1;
    for (int i = 0; i < m_dig.size(); i++) v[4*i +: 4] = 4'(m_dig[i]);
    return v;
  endfunction

  task automatic emit_pkt(input logic [PW-1:0] p);
    sb.push_back(p);
    m_pkt  = p;
    m_emit = 1'b1;
    m_dig.delete();
    m_idle = 0;
  endtask

  task automatic model_step();
    if (rst || !enable) begin
      m_dig.delete();
      m_idle = 0;
      m_emit = 1'b0;
    end else if (m_emit) begin
      m_emit = 1'b0;
    end else if (key_valid && key_code <= 4'h9) begin
      m_dig.push_front(int'(key_code));
      if (m_dig.size() > ND) void'(m_dig.pop_back());
      m_idle = 0;
    end else if (key_valid && key_code == 4'hB) begin
      emit_pkt(pack_digits());
    end else if (key_valid && key_code == 4'hA) begin
      if (m_dig.size() > 0) begin
        m_dig.delete();
        m_idle = 0;
      end else begin
        emit_pkt({ND{4'hB}});
      end
    end else if (m_dig.size() > 0) begin
      if (m_idle == TO - 1) emit_pkt({ND{4'hE}});
      else m_idle++;
    end else begin
      m_idle = 0;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // --------------------------------------------------------------------------
  // Monitor
  // --------------------------------------------------------------------------
  bit            mon_on   = 1'b0;
  logic [PW-1:0] last_pkt = '0;
  logic [PW-1:0] exp_pkt;

  initial forever begin
    @(negedge clk);
    if (mon_on) begin
      check("valid", PW'(digitos_valid), PW'(m_emit));
      check("count", PW'(digit_count), PW'(m_emit ? 0 : m_dig.size()));
      check("value", digitos_value, m_emit ? m_pkt : pack_digits());
      if (digitos_valid) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL packet: got unexpected pulse %h expected no pulse", digitos_value);
        end else begin
          exp_pkt = sb.pop_front();
          check("packet", digitos_value, exp_pkt);
        end
        last_pkt = digitos_value;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  task automatic press(input logic [3:0] c);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = c;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  int unsigned r;

  initial begin
    rst = 1'b1;
    idle(2);
    mon_on = 1'b1;
    rst    = 1'b0;
    check("rst_value", digitos_value, {ND{4'hF}});
    check("rst_count", PW'(digit_count), PW'(0));
    check("rst_valid", PW'(digitos_valid), PW'(0));

    // 1,2,3,4,'#'
    last_pkt = '0;
    press(4'h1); press(4'h2); press(4'h3); press(4'h4);
    press(4'hB);
    idle(2);
    check("pkt_1234", last_pkt, {{16{4'hF}}, 16'h1234});
    check("post_emit_value", digitos_value, {ND{4'hF}});
    check("post_emit_count", PW'(digit_count), PW'(0));

    // '#' and '*' on an empty buffer
    last_pkt = '0;
    press(4'hB);
    idle(2);
    check("pkt_skip", last_pkt, {ND{4'hF}});
    last_pkt = '0;
    press(4'hA);
    idle(2);
    check("pkt_exit", last_pkt, {ND{4'hB}});

    // 5,6,'*',7,'#'
    last_pkt = '0;
    press(4'h5); check("cnt_a", PW'(digit_count), PW'(1));
    press(4'h6); check("cnt_b", PW'(digit_count), PW'(2));
    press(4'hA); check("cnt_c", PW'(digit_count), PW'(0));
    press(4'h7); check("cnt_d", PW'(digit_count), PW'(1));
    press(4'hB);
    idle(2);
    check("pkt_7", last_pkt, {{19{4'hF}}, 4'h7});

    // 22 digits: count saturates, oldest two dropped
    last_pkt = '0;
    for (int i = 0; i < 22; i++) press(4'(i % 10));
    check("cnt_sat", PW'(digit_count), PW'(20));
    press(4'hB);
    idle(2);
    check("pkt_sat", last_pkt, 80'h23456789012345678901);

    // Timeout: pulse exactly TO cycles after the key registers
    press(4'h9);
    idle(TO - 1);
    check("tmo_early", PW'(digitos_valid), PW'(0));
    idle(1);
    check("tmo_valid", PW'(digitos_valid), PW'(1));
    check("tmo_value", digitos_value, {ND{4'hE}});
    idle(2);

    // Key landing on the expiry cycle wins
    press(4'h9);
    idle(TO - 2);
    press(4'h5);
    check("tmo_key_valid", PW'(digitos_valid), PW'(0));
    check("tmo_key_count", PW'(digit_count), PW'(2));
    press(4'hA);
    idle(2);

    // enable low clears the buffer
    last_pkt = '0;
    press(4'h3); press(4'h4);
    @(negedge clk); enable = 1'b0;
    @(negedge clk); enable = 1'b1;
    check("en_count", PW'(digit_count), PW'(0));
    press(4'hB);
    idle(2);
    check("pkt_en", last_pkt, {ND{4'hF}});

    // rst mid-entry: no pulse
    press(4'h1);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("rst2_value", digitos_value, {ND{4'hF}});
    check("rst2_count", PW'(digit_count), PW'(0));
    check("rst2_valid", PW'(digitos_valid), PW'(0));

    // Randomized traffic
    repeat (3000) begin
      @(negedge clk);
      rst       = ($urandom % 150) == 0;
      enable    = ($urandom % 40) != 0;
      key_valid = ($urandom % 4) == 0;
      r         = $urandom % 100;
      if (r < 70)      key_code = 4'($urandom % 10);
      else if (r < 80) key_code = 4'hA;
      else if (r < 88) key_code = 4'hB;
      else             key_code = 4'(12 + ($urandom % 4));
    end
    @(negedge clk);
    rst       = 1'b0;
    enable    = 1'b1;
    key_valid = 1'b0;
    idle(TO + 4);
    check("sb_empty", PW'(sb.size()), PW'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
